// File: rtl/vc_input_buffer_if.sv
// vc_input_buffer_if: flit, route, VC-allocation and switch-grant signals of one VC input buffer
interface vc_input_buffer_if #(
    parameter int FLIT_WIDTH = 64,
    parameter int PORT_WIDTH = 3,
    parameter int VC_SIZE = 2
);
    logic [FLIT_WIDTH-1:0] data_i;
    logic [FLIT_WIDTH-1:0] data_o;
    logic                  valid_flag_i;
    logic [PORT_WIDTH-1:0] out_port_i;
    logic [PORT_WIDTH-1:0] out_port_o;
    logic                  vc_request_o;
    logic                  vc_valid_i;
    logic [VC_SIZE-1:0]    vc_new_i;
    logic [VC_SIZE-1:0]    downstream_vc_o;
    logic                  read_i;
    logic                  is_empty_o;
    logic                  is_full_o;
    logic                  idle_o;
    logic                  error_o;
    modport master (
        output data_i, valid_flag_i, out_port_i, vc_valid_i, vc_new_i, read_i,
        input  data_o, out_port_o, vc_request_o, downstream_vc_o, is_empty_o, is_full_o, idle_o, error_o
    );
    modport slave (
        input  data_i, valid_flag_i, out_port_i, vc_valid_i, vc_new_i, read_i,
        output data_o, out_port_o, vc_request_o, downstream_vc_o, is_empty_o, is_full_o, idle_o, error_o
    );
endinterface

// File: rtl/vc_input_buffer.sv
// vc_input_buffer: show-ahead VC FIFO with IDLE/VA/SA state machine; VC_INPUT_BUFFER_CHECK_EN enables sticky error_o
module vc_input_buffer #(
    parameter int BUFFER_SIZE = 8,
    parameter int FLIT_WIDTH = 64,
    parameter int PORT_WIDTH = 3,
    parameter int VC_SIZE = 2
) (
    input logic clk,
    input logic rst,
    vc_input_buffer_if.slave bus
);
    localparam int AW = $clog2(BUFFER_SIZE);
    typedef enum logic [1:0] {IDLE, VA, SA} state_t;
    state_t state, state_next;
    logic [FLIT_WIDTH-1:0] mem [BUFFER_SIZE];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic [1:0] head_type;
    logic empty, full, pop, push, is_head, is_tail;
    assign empty = count == '0;
    assign full = count == (AW+1)'(BUFFER_SIZE);
    assign head_type = mem[rd_ptr][FLIT_WIDTH-1 -: 2];
    // HEAD (00) and HEADTAIL (11) open a packet; TAIL (10) and HEADTAIL close it
    assign is_head = ~^head_type;
    assign is_tail = head_type[1];
    assign pop = bus.read_i && state == SA && !empty;
    assign push = bus.valid_flag_i && (!full || pop);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (!empty && is_head ? VA : IDLE) :
                     state == VA   ? (bus.vc_valid_i ? SA : VA) :
                                     (pop && is_tail ? IDLE : SA);
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.data_i;
    always_ff @(posedge clk)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            bus.out_port_o <= '0;
            bus.downstream_vc_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == IDLE && state_next == VA) bus.out_port_o <= bus.out_port_i;
            if (state == VA && bus.vc_valid_i) bus.downstream_vc_o <= bus.vc_new_i;
        end
    assign bus.data_o = mem[rd_ptr];
    assign bus.vc_request_o = state == VA;
    assign bus.idle_o = state == IDLE && empty;
    assign bus.is_empty_o = empty;
    assign bus.is_full_o = full;
`ifdef VC_INPUT_BUFFER_CHECK_EN
    logic err;
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if ((bus.valid_flag_i && full && !pop) ||
                 (bus.read_i && state == SA && empty) ||
                 (state == IDLE && !empty && !is_head)) err <= 1'b1;
    assign bus.error_o = err;
`else
    assign bus.error_o = 1'b0;
`endif
endmodule
